// File: rtl/stepper_array_ctrl_pkg.sv
// Shared types and constants for the stepper array: phase index type, channel
// FSM states and the 8-entry unipolar half-step coil table.
package stepper_pkg;

  typedef logic [2:0] phase_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } state_t;

  // Entry k is the coil pattern for phase k; even phases are single-coil (wave) drive.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

endpackage

// File: rtl/stepper_array_ctrl_if.sv
// Per-channel request/status bundle between the dispense controller and the
// stepper array; vectors are indexed by channel, coils are 4 bits per channel.
interface stepper_array_ctrl_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0]   start;
  logic [N_CH-1:0]   dir;
  logic [N_CH-1:0]   half_step;
  logic [N_CH-1:0]   abort;
  logic [N_CH-1:0]   busy;
  logic [N_CH-1:0]   done;
  logic [4*N_CH-1:0] coils;

  modport master (
    output start, dir, half_step, abort,
    input  busy, done, coils
  );

  modport slave (
    input  start, dir, half_step, abort,
    output busy, done, coils
  );

endinterface

// File: rtl/stepper_array_ctrl_channel.sv
// One stepper channel: IDLE/RUN/HOLD sequencer with step divider, step and hold
// counters, and a registered coil output. Phase survives between moves.
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int STEP_DIV    = 125000,
  parameter int STEPS       = 4165,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dir,
  input  logic       half_step,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [3:0] coils
);

  localparam int DW = $clog2(STEP_DIV);
  localparam int SW = $clog2(STEPS + 1);
  localparam int HW = (HOLD_CYCLES == 0) ? 1 : $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(STEP_DIV - 1);
  localparam logic [SW-1:0] STEPS_INI = SW'(STEPS);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [SW-1:0] steps_left_q, steps_left_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          dir_q, dir_d;
  logic          half_q, half_d;
  logic          done_q, done_d;
  logic [3:0]    coils_q, coils_d;
  phase_t        step_phase;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    div_cnt_d    = div_cnt_q;
    steps_left_d = steps_left_q;
    hold_cnt_d   = hold_cnt_q;
    dir_d        = dir_q;
    half_d       = half_q;
    done_d       = 1'b0;
    coils_d      = 4'b0000;

    step_phase = dir_q ? phase_q + (half_q ? 3'd1 : 3'd2)
                       : phase_q - (half_q ? 3'd1 : 3'd2);

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d      = ST_RUN;
          dir_d        = dir;
          half_d       = half_step;
          div_cnt_d    = '0;
          steps_left_d = STEPS_INI;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (div_cnt_q == DIV_LAST) begin
          div_cnt_d    = '0;
          phase_d      = step_phase;
          steps_left_d = steps_left_q - 1'b1;
          if (steps_left_q == SW'(1)) begin
            if (HOLD_CYCLES == 0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d    = ST_HOLD;
              hold_cnt_d = '0;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Coils follow the next state so they are registered alongside it.
    if (state_d != ST_IDLE) begin
      coils_d = PHASE_TABLE[phase_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      div_cnt_q    <= '0;
      steps_left_q <= '0;
      hold_cnt_q   <= '0;
      dir_q        <= 1'b0;
      half_q       <= 1'b0;
      done_q       <= 1'b0;
      coils_q      <= 4'b0000;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      div_cnt_q    <= div_cnt_d;
      steps_left_q <= steps_left_d;
      hold_cnt_q   <= hold_cnt_d;
      dir_q        <= dir_d;
      half_q       <= half_d;
      done_q       <= done_d;
      coils_q      <= coils_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign coils = coils_q;

endmodule

// File: rtl/stepper_array_ctrl.sv
// N-channel stepper sequencer for the dispense spirals: independent channels,
// each a stepper_channel instance wired to its slice of the interface.
module stepper_array_ctrl #(
  parameter int N_CH        = 4,
  parameter int STEP_DIV    = 125000,
  parameter int STEPS       = 4165,
  parameter int HOLD_CYCLES = 1000
) (
  input logic                 clk,
  input logic                 rst_n,
  stepper_array_ctrl_if.slave bus
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    stepper_channel #(
      .STEP_DIV    (STEP_DIV),
      .STEPS       (STEPS),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (bus.start[gi]),
      .dir       (bus.dir[gi]),
      .half_step (bus.half_step[gi]),
      .abort     (bus.abort[gi]),
      .busy      (bus.busy[gi]),
      .done      (bus.done[gi]),
      .coils     (bus.coils[4*gi +: 4])
    );
  end

endmodule

// File: tb/tb_stepper_array_ctrl.sv
// Scoreboard bench for stepper_array_ctrl: each accepted move is expanded into
// its timed coil/done events; a negedge monitor pops and compares them.
module tb_stepper_array_ctrl;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int ST = 3;
  localparam int HD = 2;

  typedef struct {
    int         cyc;
    logic [3:0] coils;
    logic       done;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};

  ev_t        expq   [N][$];
  int         mstart [N];
  int         mend   [N];
  int         mph0   [N];
  int         mphase [N];
  bit         mdir   [N];
  bit         mhalf  [N];
  logic [3:0] prev_coils [N];

  stepper_array_ctrl_if #(.N_CH(N)) bus ();

  stepper_array_ctrl #(
    .N_CH        (N),
    .STEP_DIV    (SD),
    .STEPS       (ST),
    .HOLD_CYCLES (HD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int adv(int p, bit d, bit h);
    int s;
    s = h ? 1 : 2;
    return d ? (p + s) % 8 : (p + 8 - s) % 8;
  endfunction

  function automatic bit model_busy(int ch, int c);
    return (c >= mstart[ch] + 1) && (c < mend[ch]);
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < N; ch++) begin
      expq[ch].delete();
      mstart[ch] = -100;
      mend[ch]   = 0;
      mphase[ch] = 0;
    end
  endtask

  // Reference: a move occupies STEPS*STEP_DIV+HOLD cycles after the start cycle,
  // stepping once per STEP_DIV cycles; abort truncates it at the next cycle.
  task automatic model_cycle(int c, logic [N-1:0] s, logic [N-1:0] a,
                             logic [N-1:0] d, logic [N-1:0] h);
    int p;
    int nsteps;
    for (int ch = 0; ch < N; ch++) begin
      if (a[ch] && model_busy(ch, c)) begin
        while (expq[ch].size() > 0 && expq[ch][expq[ch].size()-1].cyc >= c + 1)
          void'(expq[ch].pop_back());
        nsteps = 0;
        for (int k = 1; k <= ST; k++)
          if (mstart[ch] + 1 + k*SD <= c) nsteps++;
        p = mph0[ch];
        for (int k = 0; k < nsteps; k++) p = adv(p, mdir[ch], mhalf[ch]);
        mphase[ch] = p;
        mend[ch]   = c + 1;
        expq[ch].push_back('{c + 1, 4'b0000, 1'b0});
      end else if (s[ch] && !a[ch] && !model_busy(ch, c)) begin
        mstart[ch] = c;
        mph0[ch]   = mphase[ch];
        mdir[ch]   = d[ch];
        mhalf[ch]  = h[ch];
        p = mphase[ch];
        expq[ch].push_back('{c + 1, tbl[p], 1'b0});
        for (int k = 1; k <= ST; k++) begin
          p = adv(p, d[ch], h[ch]);
          expq[ch].push_back('{c + 1 + k*SD, tbl[p], 1'b0});
        end
        mend[ch]   = c + 1 + ST*SD + HD;
        mphase[ch] = p;
        expq[ch].push_back('{mend[ch], 4'b0000, 1'b1});
      end
    end
  endtask

  task automatic step(logic [N-1:0] s, logic [N-1:0] a, logic [N-1:0] d, logic [N-1:0] h);
    bus.start     = s;
    bus.abort     = a;
    bus.dir       = d;
    bus.half_step = h;
    model_cycle(cyc, s, a, d, h);
    @(posedge clk);
    #1;
    bus.start = '0;
    bus.abort = '0;
  endtask

  task automatic idle(int n);
    repeat (n) step('0, '0, '0, '0);
  endtask

  task automatic check_reset_outputs(string tag);
    compared++;
    if (bus.busy !== '0) begin
      mismatched++;
      $display("FAIL %s busy: got %b expected 0000", tag, bus.busy);
    end
    compared++;
    if (bus.done !== '0) begin
      mismatched++;
      $display("FAIL %s done: got %b expected 0000", tag, bus.done);
    end
    compared++;
    if (bus.coils !== 16'h0000) begin
      mismatched++;
      $display("FAIL %s coils: got %h expected 0000", tag, bus.coils);
    end
  endtask

  // Monitor: busy every cycle, and one queued event per coil change or done pulse.
  always @(negedge clk) begin
    for (int ch = 0; ch < N; ch++) begin
      logic [3:0] c4;
      ev_t        e;
      c4 = bus.coils[4*ch +: 4];
      if (rst_n) begin
        compared++;
        if (bus.busy[ch] !== model_busy(ch, cyc)) begin
          mismatched++;
          $display("FAIL busy ch%0d cyc%0d: got %b expected %b",
                   ch, cyc, bus.busy[ch], model_busy(ch, cyc));
        end
        if (c4 !== prev_coils[ch] || bus.done[ch] !== 1'b0) begin
          compared++;
          if (expq[ch].size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_event ch%0d cyc%0d: got coils=%b done=%b expected no event",
                     ch, cyc, c4, bus.done[ch]);
          end else begin
            e = expq[ch].pop_front();
            if (e.cyc != cyc || e.coils !== c4 || e.done !== bus.done[ch]) begin
              mismatched++;
              $display("FAIL event ch%0d: got cyc%0d coils=%b done=%b expected cyc%0d coils=%b done=%b",
                       ch, cyc, c4, bus.done[ch], e.cyc, e.coils, e.done);
            end else begin
              $display("event ch%0d cyc%0d coils=%b done=%b ok", ch, cyc, c4, bus.done[ch]);
            end
          end
        end
      end
      prev_coils[ch] = c4;
    end
  end

  initial begin
    bus.start = '0;
    bus.abort = '0;
    bus.dir = '0;
    bus.half_step = '0;
    for (int ch = 0; ch < N; ch++) prev_coils[ch] = 4'b0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_outputs("reset_release");
    idle(6);

    // ch0 forward half-step
    step(4'b0001, '0, 4'b0001, 4'b0001);
    idle(16);
    // ch1 reverse full-step from phase 0, then a second move resuming at phase 2
    step(4'b0010, '0, '0, '0);
    idle(16);
    step(4'b0010, '0, '0, '0);
    idle(16);
    // ch2 abort six cycles after start, then start+abort together
    step(4'b0100, '0, 4'b0100, 4'b0100);
    idle(5);
    step('0, 4'b0100, '0, '0);
    idle(3);
    step(4'b0100, 4'b0100, 4'b0100, '0);
    idle(4);
    // ch3 re-pulsed while busy
    step(4'b1000, '0, 4'b1000, '0);
    idle(4);
    step(4'b1000, '0, '0, 4'b1000);
    idle(12);
    // simultaneous starts on ch0..ch2
    step(4'b0111, '0, 4'b0101, 4'b0011);
    idle(16);

    // asynchronous reset in the middle of a move
    step(4'b0001, '0, 4'b0001, '0);
    idle(5);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b0001, '0, 4'b0001, 4'b0001);
    idle(16);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] s, a, d, h;
      for (int ch = 0; ch < N; ch++) begin
        s[ch] = ($urandom_range(5) == 0);
        a[ch] = ($urandom_range(49) == 0);
        d[ch] = $urandom_range(1);
        h[ch] = $urandom_range(1);
      end
      step(s, a, d, h);
    end
    idle(20);

    for (int ch = 0; ch < N; ch++) begin
      compared++;
      if (expq[ch].size() != 0) begin
        mismatched++;
        $display("FAIL pending_events ch%0d: got %0d outstanding expected 0",
                 ch, expq[ch].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
